// File: rtl/wallace_pkg.sv
// Shared helpers for the pipelined Wallace multiplier: product width, reduction-tree
// sizing and the Baugh-Wooley correction constant.
package wallace_pkg;

   typedef enum logic {
      MODE_UNSIGNED = 1'b0,
      MODE_SIGNED   = 1'b1
   } mul_mode_e;

   function automatic int PROD_W(input int w);
      return 2 * w;
   endfunction

   // Rows left after one 3:2 level: each group of three becomes two, leftovers stay.
   function automatic int csa_rows_out(input int n);
      return 2 * (n / 3) + (n % 3);
   endfunction

   function automatic int rows_at_level(input int n, input int lvl);
      int r;
      r = n;
      for (int k = 0; k < lvl; k++) begin
         if (r > 2) r = csa_rows_out(r);
      end
      return r;
   endfunction

   function automatic int reduction_depth(input int n);
      int r;
      int d;
      r = n;
      d = 0;
      for (int k = 0; k < 64; k++) begin
         if (r > 2) begin
            r = csa_rows_out(r);
            d = d + 1;
         end
      end
      return d;
   endfunction

   // Ones at bit w and bit 2w-1 complete the inverted sign-row terms.
   function automatic logic [63:0] bw_correction(input int w);
      return (64'd1 << w) | (64'd1 << (2 * w - 1));
   endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One Wallace reduction level: full adders on each group of three rows, a half adder
// on a two-row leftover, a single leftover row passes straight through.
module wallace_csa_row
   import wallace_pkg::*;
#(
   parameter int N_IN  = 3,
   parameter int W     = 16,
   parameter int N_OUT = csa_rows_out(N_IN)
) (
   input  logic [N_IN-1:0][W-1:0]  i_rows,
   output logic [N_OUT-1:0][W-1:0] o_rows
);

   localparam int N_GRP  = N_IN / 3;
   localparam int N_LEFT = N_IN % 3;

   genvar gi;
   generate
      for (gi = 0; gi < N_GRP; gi++) begin : g_fa
         assign o_rows[2*gi] = i_rows[3*gi] ^ i_rows[3*gi+1] ^ i_rows[3*gi+2];
         // Carry row is shifted up one column; the top carry falls outside the product.
         assign o_rows[2*gi+1] = {(i_rows[3*gi][W-2:0]   & i_rows[3*gi+1][W-2:0]) |
                                  (i_rows[3*gi][W-2:0]   & i_rows[3*gi+2][W-2:0]) |
                                  (i_rows[3*gi+1][W-2:0] & i_rows[3*gi+2][W-2:0]), 1'b0};
      end

      if (N_LEFT == 2) begin : g_ha
         assign o_rows[2*N_GRP]   = i_rows[3*N_GRP] ^ i_rows[3*N_GRP+1];
         assign o_rows[2*N_GRP+1] = {i_rows[3*N_GRP][W-2:0] & i_rows[3*N_GRP+1][W-2:0], 1'b0};
      end else if (N_LEFT == 1) begin : g_pass
         assign o_rows[2*N_GRP] = i_rows[3*N_GRP];
      end
   endgenerate

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace multiplier, signed/unsigned per operation, valid/ready
// on both sides. Define WALLACE_MULT_ACC_EN to add the in_acc accumulate option.
module wallace_mult_pipe
   import wallace_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   input  logic                  in_signed,
   input  logic [TAG_W-1:0]      in_tag,
`ifdef WALLACE_MULT_ACC_EN
   input  logic                  in_acc,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*WIDTH-1:0]    out_prod,
   output logic [TAG_W-1:0]      out_tag
);

   localparam int PW     = PROD_W(WIDTH);
   localparam int N_ROWS = WIDTH + 1;
   localparam int DEPTH  = reduction_depth(N_ROWS);
   localparam logic [PW-1:0] BW_CORR = PW'(bw_correction(WIDTH));

   logic w_adv;

   logic             r_s0_valid;
   logic [WIDTH-1:0] r_s0_a;
   logic [WIDTH-1:0] r_s0_b;
   mul_mode_e        r_s0_mode;
   logic [TAG_W-1:0] r_s0_tag;

   logic             r_s1_valid;
   logic [PW-1:0]    r_s1_sum;
   logic [PW-1:0]    r_s1_carry;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_out_valid;
   logic [PW-1:0]    r_out_prod;
   logic [TAG_W-1:0] r_out_tag;

   logic                          w_signed;
   logic [N_ROWS-1:0][PW-1:0]     w_rows0;
   logic [PW-1:0]                 w_red_sum;
   logic [PW-1:0]                 w_red_carry;
   logic [PW-1:0]                 w_s2_prod;

   // Whole pipeline moves in lockstep; bubbles are never squeezed out.
   assign w_adv    = ~r_out_valid | out_ready;
   assign in_ready = w_adv;

   assign out_valid = r_out_valid;
   assign out_prod  = r_out_prod;
   assign out_tag   = r_out_tag;

`ifdef WALLACE_MULT_ACC_EN
   logic          r_s0_acc;
   logic          r_s1_acc;
   logic [PW-1:0] r_acc;
   logic [PW-1:0] w_acc_src;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0_valid <= 1'b0;
         r_s0_a     <= '0;
         r_s0_b     <= '0;
         r_s0_mode  <= MODE_UNSIGNED;
         r_s0_tag   <= '0;
`ifdef WALLACE_MULT_ACC_EN
         r_s0_acc   <= 1'b0;
`endif
      end else if (w_adv) begin
         r_s0_valid <= in_valid;
         if (in_valid) begin
            r_s0_a    <= in_a;
            r_s0_b    <= in_b;
            r_s0_mode <= mul_mode_e'(in_signed);
            r_s0_tag  <= in_tag;
`ifdef WALLACE_MULT_ACC_EN
            r_s0_acc  <= in_acc;
`endif
         end
      end
   end

   assign w_signed = (r_s0_mode == MODE_SIGNED);

   genvar gi, gj;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_pp
         logic [WIDTH-1:0] w_bits;
         for (gj = 0; gj < WIDTH; gj++) begin : g_bit
            // Baugh-Wooley: invert terms pairing exactly one sign bit with a magnitude bit.
            localparam logic INV = ((gi == WIDTH - 1) != (gj == WIDTH - 1));
            assign w_bits[gj] = (r_s0_a[gj] & r_s0_b[gi]) ^ (w_signed & INV);
         end
         assign w_rows0[gi] = {{WIDTH{1'b0}}, w_bits} << gi;
      end

      assign w_rows0[WIDTH] = w_signed ? BW_CORR : '0;

      for (gi = 0; gi < DEPTH; gi++) begin : g_lvl
         localparam int NI = rows_at_level(N_ROWS, gi);
         localparam int NO = csa_rows_out(NI);
         logic [NO-1:0][PW-1:0] w_rows;
         if (gi == 0) begin : g_first
            wallace_csa_row #(
               .N_IN (NI),
               .W    (PW)
            ) u_row (
               .i_rows (w_rows0),
               .o_rows (w_rows)
            );
         end else begin : g_next
            wallace_csa_row #(
               .N_IN (NI),
               .W    (PW)
            ) u_row (
               .i_rows (g_lvl[gi-1].w_rows),
               .o_rows (w_rows)
            );
         end
      end
   endgenerate

   assign w_red_sum   = g_lvl[DEPTH-1].w_rows[0];
   assign w_red_carry = g_lvl[DEPTH-1].w_rows[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
         r_s1_carry <= '0;
         r_s1_tag   <= '0;
`ifdef WALLACE_MULT_ACC_EN
         r_s1_acc   <= 1'b0;
`endif
      end else if (w_adv) begin
         r_s1_valid <= r_s0_valid;
         if (r_s0_valid) begin
            r_s1_sum   <= w_red_sum;
            r_s1_carry <= w_red_carry;
            r_s1_tag   <= r_s0_tag;
`ifdef WALLACE_MULT_ACC_EN
            r_s1_acc   <= r_s0_acc;
`endif
         end
      end
   end

`ifdef WALLACE_MULT_ACC_EN
   // When S2 loads while a result is showing, that result is being delivered this
   // same edge, so it is already the "previous delivered" value.
   assign w_acc_src = r_out_valid ? r_out_prod : r_acc;
   assign w_s2_prod = r_s1_sum + r_s1_carry + (r_s1_acc ? w_acc_src : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (r_out_valid && out_ready) begin
         r_acc <= r_out_prod;
      end
   end
`else
   assign w_s2_prod = r_s1_sum + r_s1_carry;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_prod  <= '0;
         r_out_tag   <= '0;
      end else if (w_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_prod <= w_s2_prod;
            r_out_tag  <= r_s1_tag;
         end
      end
   end

endmodule
